chase_steer: RTL

//  Consumes the colour tracker's blob estimate (x_center, radius) and turns it into differential-drive motor commands.
//  FSM searches for the target, steers proportionally toward it, and holds when close; it falls back to search when the target is lost.

---
 rtl/chase_steer_if.sv | 28 ++
 rtl/chase_steer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chase_steer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : chase_steer_if                                                  |
// | Purpose  : Measurement bus from the colour tracker to the steering block.  |
// |            meas_valid is a one-cycle strobe; x_center/radius carry the     |
// |            blob estimate that goes with it.                                |
// | Signals  : meas_valid (1), x_center (32, unsigned), radius (24, unsigned)  |
// | Modports : master = tracker side (drives), slave = steering side (reads)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface chase_steer_if;
  logic        meas_valid;
  logic [31:0] x_center;
  logic [23:0] radius;

  modport master (
    output meas_valid,
    output x_center,
    output radius
  );

  modport slave (
    input meas_valid,
    input x_center,
    input radius
  );
endinterface
`default_nettype wire

// File: rtl/chase_steer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : chase_steer                                                     |
// | Purpose  : Turns the tracker's blob estimate into differential-drive       |
// |            motor commands. A small FSM searches (spins), tracks with a     |
// |            proportional steering correction, and holds when the target is  |
// |            close. Each wheel gets an 8-bit-duty PWM and a direction bit.   |
// | Ports    : clk        in   system clock                                    |
// |            reset      in   asynchronous reset, active low                  |
// |            enable     in   level; 0 forces IDLE and motors off             |
// |            meas       in   chase_steer_if.slave measurement bus            |
// |            pwm_left   out  left motor PWM                                  |
// |            pwm_right  out  right motor PWM                                 |
// |            dir_left   out  1 = forward, 0 = reverse                        |
// |            dir_right  out  1 = forward, 0 = reverse                        |
// |            state      out  0 IDLE, 1 SEARCH, 2 TRACK, 3 HOLD               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module chase_steer #(
  parameter int CENTER_X    = 512,
  parameter int MIN_RADIUS  = 4,
  parameter int STOP_RADIUS = 60,
  parameter int HYST        = 8,
  parameter int BASE_DUTY   = 160,
  parameter int SEARCH_DUTY = 100,
  parameter int KP_SHIFT    = 2,
  parameter int LOST_COUNT  = 5,
  parameter int TIMEOUT     = 13_000_000,
  parameter int PWM_DIV     = 10
) (
  input  wire          clk,
  input  wire          reset,
  input  wire          enable,
  chase_steer_if.slave meas,
  output logic         pwm_left,
  output logic         pwm_right,
  output logic         dir_left,
  output logic         dir_right,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_TRACK  = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam int c_IDLE_W    = $clog2(TIMEOUT + 1);
  localparam int c_LOST_W    = $clog2(LOST_COUNT + 1);
  localparam int c_PRE_W     = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int c_PRE_MAX_I = PWM_DIV - 1;
  localparam int c_EXIT_R_I  = STOP_RADIUS - HYST;

  localparam logic [15:0]          c_MIN_R    = MIN_RADIUS[15:0];
  localparam logic [15:0]          c_STOP_R   = STOP_RADIUS[15:0];
  localparam logic [15:0]          c_EXIT_R   = c_EXIT_R_I[15:0];
  localparam logic signed [11:0]   c_CENTER   = CENTER_X[11:0];
  localparam logic signed [12:0]   c_BASE     = BASE_DUTY[12:0];
  localparam logic [7:0]           c_SEARCH_D = SEARCH_DUTY[7:0];
  localparam logic [c_IDLE_W-1:0]  c_TIMEOUT  = TIMEOUT[c_IDLE_W-1:0];
  localparam logic [c_LOST_W-1:0]  c_LOST     = LOST_COUNT[c_LOST_W-1:0];
  localparam logic [c_PRE_W-1:0]   c_PRE_MAX  = c_PRE_MAX_I[c_PRE_W-1:0];

  // Saturate a signed sum into the 0..255 duty range.
  function automatic logic [7:0] sat8(input logic signed [12:0] v);
    if (v < 13'sd0)        return 8'd0;
    else if (v > 13'sd255) return 8'hFF;
    else                   return v[7:0];
  endfunction

  // ---------------------------------------------------------------- stage 1
  logic        r_s1_valid;
  logic [9:0]  r_x;
  logic [15:0] r_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_x        <= '0;
      r_r        <= '0;
    end else begin
      // Strobes seen while disabled never reach the FSM.
      r_s1_valid <= meas.meas_valid & enable;
      if (meas.meas_valid && enable) begin
        r_x <= (meas.x_center > 32'd1023) ? 10'd1023 : meas.x_center[9:0];
        r_r <= (meas.radius > 24'd65535) ? 16'hFFFF : meas.radius[15:0];
      end
    end
  end

  // ---------------------------------------------------------------- steering
  logic signed [11:0] w_err;
  logic signed [11:0] w_corr;
  logic signed [12:0] w_left_raw;
  logic signed [12:0] w_right_raw;

  assign w_err       = $signed({2'b00, r_x}) - c_CENTER;
  assign w_corr      = w_err >>> KP_SHIFT;
  assign w_left_raw  = c_BASE + $signed({w_corr[11], w_corr});
  assign w_right_raw = c_BASE - $signed({w_corr[11], w_corr});

  // ---------------------------------------------------------------- stage 2 FSM
  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_LOST_W-1:0] r_lost;
  logic [c_LOST_W-1:0] w_lost_nxt;
  logic [c_IDLE_W-1:0] r_idle;
  logic [c_IDLE_W-1:0] w_idle_nxt;
  logic [7:0]          r_pend_l;
  logic [7:0]          r_pend_r;
  logic                r_pend_dl;
  logic                r_pend_dr;
  logic [7:0]          w_pend_l;
  logic [7:0]          w_pend_r;
  logic                w_pend_dl;
  logic                w_pend_dr;
  logic                w_sample_ok;
  logic                w_sample_bad;

  always_comb begin
    w_state_nxt  = r_state;
    w_lost_nxt   = r_lost;
    w_idle_nxt   = r_idle;
    w_pend_l     = r_pend_l;
    w_pend_r     = r_pend_r;
    w_pend_dl    = r_pend_dl;
    w_pend_dr    = r_pend_dr;
    w_sample_ok  = r_s1_valid && (r_r >= c_MIN_R);
    w_sample_bad = r_s1_valid && (r_r < c_MIN_R);

    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_SEARCH;
        S_SEARCH: begin
          if (w_sample_ok)
            w_state_nxt = (r_r >= c_STOP_R) ? S_HOLD : S_TRACK;
        end
        S_TRACK, S_HOLD: begin
          w_idle_nxt = r_s1_valid ? '0 : r_idle + 1'b1;
          if (w_sample_ok)       w_lost_nxt = '0;
          else if (w_sample_bad) w_lost_nxt = r_lost + 1'b1;

          // A valid sample clears both loss counters, so the fall-back
          // conditions below can only fire on invalid samples or silence.
          if (r_state == S_TRACK && w_sample_ok && r_r >= c_STOP_R)
            w_state_nxt = S_HOLD;
          else if (r_state == S_HOLD && w_sample_ok && r_r < c_EXIT_R)
            w_state_nxt = S_TRACK;
          else if (w_lost_nxt >= c_LOST || w_idle_nxt >= c_TIMEOUT)
            w_state_nxt = S_SEARCH;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    if (w_state_nxt != r_state) begin
      w_lost_nxt = '0;
      w_idle_nxt = '0;
    end

    case (w_state_nxt)
      S_TRACK: begin
        // Without a fresh sample keep steering with the last correction.
        if (w_sample_ok) begin
          w_pend_l = sat8(w_left_raw);
          w_pend_r = sat8(w_right_raw);
        end
        w_pend_dl = 1'b1;
        w_pend_dr = 1'b1;
      end
      S_SEARCH: begin
        w_pend_l  = c_SEARCH_D;
        w_pend_r  = c_SEARCH_D;
        w_pend_dl = 1'b1;
        w_pend_dr = 1'b0;
      end
      default: begin
        w_pend_l  = 8'd0;
        w_pend_r  = 8'd0;
        w_pend_dl = 1'b1;
        w_pend_dr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_lost    <= '0;
      r_idle    <= '0;
      r_pend_l  <= 8'd0;
      r_pend_r  <= 8'd0;
      r_pend_dl <= 1'b1;
      r_pend_dr <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_lost    <= w_lost_nxt;
      r_idle    <= w_idle_nxt;
      r_pend_l  <= w_pend_l;
      r_pend_r  <= w_pend_r;
      r_pend_dl <= w_pend_dl;
      r_pend_dr <= w_pend_dr;
    end
  end

  // ---------------------------------------------------------------- PWM
  logic [c_PRE_W-1:0] r_pre;
  logic [7:0]         r_pwm_cnt;
  logic [7:0]         r_act_l;
  logic [7:0]         r_act_r;
  logic               r_act_dl;
  logic               r_act_dr;
  logic               r_pwm_l;
  logic               r_pwm_r;
  logic               w_pre_wrap;

  assign w_pre_wrap = (r_pre == c_PRE_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre     <= '0;
      r_pwm_cnt <= 8'd0;
      r_act_l   <= 8'd0;
      r_act_r   <= 8'd0;
      r_act_dl  <= 1'b1;
      r_act_dr  <= 1'b1;
      r_pwm_l   <= 1'b0;
      r_pwm_r   <= 1'b0;
    end else begin
      if (w_pre_wrap) begin
        r_pre     <= '0;
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end

      // Disable kills the motors right away; otherwise duties and
      // directions change only at the period boundary (cnt 255 -> 0).
      if (!enable) begin
        r_act_l  <= 8'd0;
        r_act_r  <= 8'd0;
        r_act_dl <= 1'b1;
        r_act_dr <= 1'b1;
      end else if (w_pre_wrap && r_pwm_cnt == 8'hFF) begin
        r_act_l  <= r_pend_l;
        r_act_r  <= r_pend_r;
        r_act_dl <= r_pend_dl;
        r_act_dr <= r_pend_dr;
      end

      r_pwm_l <= enable && (r_pwm_cnt < r_act_l);
      r_pwm_r <= enable && (r_pwm_cnt < r_act_r);
    end
  end

  assign pwm_left  = r_pwm_l;
  assign pwm_right = r_pwm_r;
  assign dir_left  = r_act_dl;
  assign dir_right = r_act_dr;
  assign state     = r_state;

endmodule
`default_nettype wire
